vga_draw_arbiter: RTL
=====================

Name: vga_draw_arbiter

Overview:
- Shares the single VGA adapter pixel write port (x, y, colour, plot) among independent draw engines: maze scan, player draw, player erase, special boxes, full-screen images.
- Replaces ad-hoc combinational muxing with an explicit request/grant handshake, registered pixel outputs, coordinate clipping and a hold-time watchdog.
- Sits between the draw engines and vga_adapter.
- The game FSM observes busy/owner instead of individual done flags.

Parameters:
- NUM_REQ, 5, number of requesters; index 0 is highest priority in fixed mode.
- MAX_HOLD, 131072, maximum cycles one grant may be held before forced release.
- X_MAX, 320, x values >= X_MAX are clipped (no plot).
- Y_MAX, 240, y values >= Y_MAX are clipped (no plot).

Ports:
- clk  in  1  system clock (CLOCK_50 at top).
- resetn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester draw request, level; held high for the whole region.
- done_in  in  NUM_REQ  per-requester end-of-region pulse, valid only while granted.
- x_in  in  9*NUM_REQ  packed x coordinates; requester i uses bits [9i+8:9i].
- y_in  in  9*NUM_REQ  packed y coordinates; requester i uses bits [9i+8:9i].
- colour_in  in  3*NUM_REQ  packed colours; requester i uses bits [3i+2:3i].
- grant  out  NUM_REQ  one-hot grant, or zero.
- x  out  9  registered pixel x to vga_adapter.
- y  out  9  registered pixel y to vga_adapter.
- colour  out  3  registered pixel colour.
- plot  out  1  registered write enable.
- busy  out  1  high in GRANT and RELEASE.
- owner  out  3  index of current/last grantee.
- timeout_err  out  1  sticky; set on watchdog release.

Behaviour:
- Reset (asynchronous, active-low):
  - grant=0, x=0, y=0, colour=0, plot=0, busy=0, owner=0, timeout_err=0.
  - State IDLE, hold counter 0, round-robin pointer 0.
- IDLE:
  - plot=0, grant=0.
  - If req!=0, select a winner, assert grant[w] on the next edge, load owner=w, clear hold counter, go to GRANT.
  - Fixed priority (default): lowest index wins.
- GRANT:
  - Each cycle, register x_in[w], y_in[w], colour_in[w] into x/y/colour.
  - plot is set to 1 unless x_in[w]>=X_MAX or y_in[w]>=Y_MAX, in which case plot=0 and the coordinates are still registered.
  - Pixel latency is 1 cycle from input to output.
  - Hold counter increments every cycle.
- Leaving GRANT (go to RELEASE) on any of:
  - done_in[w]=1 — the pixel presented in that cycle is still plotted;
  - req[w]=0 — that cycle is not plotted;
  - hold counter reaching MAX_HOLD-1 — set timeout_err=1.
- RELEASE:
  - Exactly one cycle; grant=0, plot=0, busy=1.
  - Always returns to IDLE, so re-arbitration happens at earliest 2 cycles after done.
- Input qualification:
  - done_in from non-granted requesters is ignored.
  - req changes from non-granted requesters are ignored until IDLE.
- Simultaneous events:
  - done_in[w] and a new req[j] in the same cycle: release first, j is granted via IDLE.
  - done_in[w] together with the watchdog limit counts as a normal done; timeout_err is not set.
- Requester held: a requester keeping req high after done is re-granted only through a fresh IDLE arbitration.
- owner holds its value in IDLE.
- timeout_err is cleared only by reset.
- Hold counter width is ceil(log2(MAX_HOLD)); no wrap is possible because release occurs at MAX_HOLD-1.
- Reset mid-GRANT: outputs are cleared immediately (asynchronous); any pixel in flight is dropped.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - IDLE selects the first asserted req at or after the RR pointer, wrapping modulo NUM_REQ.
  - On entering RELEASE, the pointer becomes (w+1) mod NUM_REQ.
  - A requester that keeps req high after done yields to any other pending requester.
- Undefined: fixed priority, lowest index wins; no pointer register is synthesised.

Test Plan:
1. Reset, req=5'b00001, x_in[0]=10, y_in[0]=20, colour 3'b101, done after 4 cycles -> grant=00001 one cycle after req; plot=1 with x=10, y=20, colour=101 one cycle later; 4 plotted pixels; RELEASE; busy=0 two cycles after done.
2. req=5'b10010 simultaneously, fixed priority -> grant=00010 first; after its done, grant=10000 following RELEASE+IDLE.
3. Requester 2 granted, drives x=319 then 320, y=239 -> plot=1 for x=319, plot=0 for x=320; x output still shows 320.
4. MAX_HOLD=16 override; requester 3 holds req with no done -> grant dropped after 16 cycles; timeout_err=1 and stays 1 until resetn low.
5. Requester 1 drops req mid-region after 3 pixels -> 3 plots only, then RELEASE, then IDLE.
6. ARB_ROUND_ROBIN_EN defined, req=5'b00011 held continuously, done pulses each region -> grant alternates 00001, 00010, 00001; resetn asserted mid-GRANT -> grant=0, plot=0 the same cycle.

Source files
------------

// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: shares the single vga_adapter pixel write port among
// several draw engines using a request/grant handshake. Pixel outputs are
// registered, off-screen pixels are clipped, and a hold-time watchdog forces
// release of a grant that is held too long.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   req[N]               per-requester level request, held for the whole region
//   done_in[N]           per-requester end-of-region pulse (only owner's counts)
//   x_in/y_in[9*N]       packed coordinates, requester i at [9i+8:9i]
//   colour_in[3*N]       packed colours, requester i at [3i+2:3i]
//   grant[N]             one-hot grant or zero
//   x, y, colour, plot   registered pixel write to vga_adapter
//   busy                 high while granting or releasing
//   owner                index of current/last grantee
//   timeout_err          sticky watchdog-release flag
//
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority with the lowest index winning.
module vga_draw_arbiter #(
    parameter int unsigned NUM_REQ  = 5,
    parameter int unsigned MAX_HOLD = 131072,
    parameter int unsigned X_MAX    = 320,
    parameter int unsigned Y_MAX    = 240
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     done_in,
    input  logic [9*NUM_REQ-1:0]   x_in,
    input  logic [9*NUM_REQ-1:0]   y_in,
    input  logic [3*NUM_REQ-1:0]   colour_in,
    output logic [NUM_REQ-1:0]     grant,
    output logic [8:0]             x,
    output logic [8:0]             y,
    output logic [2:0]             colour,
    output logic                   plot,
    output logic                   busy,
    output logic [2:0]             owner,
    output logic                   timeout_err
);

    localparam int unsigned COORD_W = 9;
    localparam int unsigned COL_W   = 3;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned HOLD_W  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
    logic [COL_W-1:0]     colour_q, colour_d;
    logic                 plot_q, plot_d;
    logic                 busy_q, busy_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 terr_q, terr_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]     ptr_q, ptr_d;
`endif

    logic                 win_vld;
    logic [IDX_W-1:0]     win_idx;
    logic [COORD_W-1:0]   cur_x, cur_y;
    logic [COL_W-1:0]     cur_col;
    logic                 cur_in_range;
    logic                 leave;

    // Owner's pixel and on-screen qualification
    assign cur_x        = x_in[COORD_W*owner_q +: COORD_W];
    assign cur_y        = y_in[COORD_W*owner_q +: COORD_W];
    assign cur_col      = colour_in[COL_W*owner_q +: COL_W];
    assign cur_in_range = (32'(cur_x) < X_MAX) && (32'(cur_y) < Y_MAX);

    // Winner selection among pending requests
    always_comb begin : p_win
        int unsigned rr_idx;
        rr_idx  = 0;
        win_vld = 1'b0;
        win_idx = '0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rr_idx = (32'(ptr_q) + k) % NUM_REQ;
            if (!win_vld && req[rr_idx]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(rr_idx);
            end
        end
`else
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = busy_q;
        owner_d  = owner_q;
        hold_d   = hold_q;
        terr_d   = terr_q;
        leave    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (win_vld) begin
                    state_d = ST_GRANT;
                    grant_d = NUM_REQ'(1) << win_idx;
                    owner_d = win_idx;
                    hold_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_GRANT: begin
                x_d      = cur_x;
                y_d      = cur_y;
                colour_d = cur_col;
                hold_d   = hold_q + HOLD_W'(1);
                // done outranks a dropped req, which outranks the watchdog
                if (done_in[owner_q]) begin
                    plot_d = cur_in_range;
                    leave  = 1'b1;
                end else if (!req[owner_q]) begin
                    leave  = 1'b1;
                end else begin
                    plot_d = cur_in_range;
                    if (hold_q == HOLD_LAST) begin
                        leave  = 1'b1;
                        terr_d = 1'b1;
                    end
                end
                if (leave) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                    hold_d  = hold_q;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
`endif
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            owner_q  <= '0;
            hold_q   <= '0;
            terr_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            owner_q  <= owner_d;
            hold_q   <= hold_d;
            terr_q   <= terr_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign x           = x_q;
    assign y           = y_q;
    assign colour      = colour_q;
    assign plot        = plot_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign timeout_err = terr_q;

endmodule
